// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register file and its
// LUI write-back path.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    function automatic logic [XLEN-1:0] lui_value(input logic [19:0] imm20);
        return {imm20, 12'h000};
    endfunction

endpackage

// File: rtl/lui_skid.sv
// One-entry buffer holding a LUI {rd, imm20} that lost write-port
// arbitration to an ALU write-back.
module lui_skid
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [REG_AW-1:0] load_rd,
    input  logic [19:0]       load_imm,
    input  logic              drain,
    output logic              full,
    output logic [REG_AW-1:0] rd,
    output logic [19:0]       imm
);

    skid_state_t state, state_next;
    logic [REG_AW-1:0] rd_q;
    logic [19:0]       imm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SKID_EMPTY;
            rd_q  <= '0;
            imm_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                rd_q  <= load_rd;
                imm_q <= load_imm;
            end
        end
    end

    // The top never loads while full, so load only matters when empty.
    always_comb begin
        state_next = state;
        case (state)
            SKID_EMPTY: if (load)  state_next = SKID_FULL;
            SKID_FULL:  if (drain) state_next = SKID_EMPTY;
            default:    state_next = SKID_EMPTY;
        endcase
    end

    assign full = (state == SKID_FULL);
    assign rd   = rd_q;
    assign imm  = imm_q;

endmodule

// File: rtl/reg_file_wb.sv
// 32 x XLEN register file with one arbitrated write port (ALU write-back,
// then held LUI, then fresh LUI) and two bypassed, registered read ports.
module reg_file_wb
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              lui_pending,
    output logic [REG_AW-1:0] lui_pend_rd
);

    logic [XLEN-1:0] regs [NREG];

    logic              skid_full;
    logic [REG_AW-1:0] skid_rd;
    logic [19:0]       skid_imm;
    logic              skid_load;
    logic              skid_drain;

    logic    lui_accept;
    wb_req_t wr;

    assign instr_ready = !skid_full;
    assign lui_accept  = instr_valid && instr_ready && (instr[6:0] == OPC_LUI);
    assign skid_load   = lui_accept && wb_valid;

    lui_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .load_rd  (instr[11:7]),
        .load_imm (instr[31:12]),
        .drain    (skid_drain),
        .full     (skid_full),
        .rd       (skid_rd),
        .imm      (skid_imm)
    );

    // Single write port: ALU first, then the held LUI, then a fresh LUI.
    // A write targeting x0 is squashed here so x0 never changes.
    always_comb begin
        wr         = '0;
        skid_drain = 1'b0;
        if (wb_valid) begin
            wr.valid = 1'b1;
            wr.rd    = wb_rd;
            wr.data  = wb_data;
        end else if (skid_full) begin
            wr.valid   = 1'b1;
            wr.rd      = skid_rd;
            wr.data    = lui_value(skid_imm);
            skid_drain = 1'b1;
        end else if (lui_accept) begin
            wr.valid = 1'b1;
            wr.rd    = instr[11:7];
            wr.data  = lui_value(instr[31:12]);
        end
        if (wr.rd == '0) begin
            wr.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr.valid) begin
            regs[wr.rd] <= wr.data;
        end
    end

    // Read registers forward a same-edge write so consumers never see stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            if (rs1_addr == '0)
                rs1_data <= '0;
            else if (wr.valid && wr.rd == rs1_addr)
                rs1_data <= wr.data;
            else
                rs1_data <= regs[rs1_addr];

            if (rs2_addr == '0)
                rs2_data <= '0;
            else if (wr.valid && wr.rd == rs2_addr)
                rs2_data <= wr.data;
            else
                rs2_data <= regs[rs2_addr];
        end
    end

    assign lui_pending = skid_full;
    assign lui_pend_rd = skid_full ? skid_rd : '0;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: reset, LUI, arbitration,
// skid hold/drain, bypass, x0 handling and mid-operation reset.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        lui_pending;
    logic [4:0]  lui_pend_rd;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] ALU = 7'b0110011;

    reg_file_wb dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .lui_pending (lui_pending),
        .lui_pend_rd (lui_pend_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ins,
                                 input logic wv, input logic [4:0] wrd,
                                 input logic [31:0] wd,
                                 input logic [4:0] a1, input logic [4:0] a2);
        instr_valid = iv;
        instr       = ins;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        rs1_addr    = a1;
        rs2_addr    = a2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, LUI};
    endfunction

    initial begin
        reset = 1'b0;
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) tick();
        checkOutput("rst_pending", {31'b0, lui_pending}, 32'h0);
        checkOutput("rst_pend_rd", {27'b0, lui_pend_rd}, 32'h0);
        checkOutput("rst_rs1",     rs1_data, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("rst_ready", {31'b0, instr_ready}, 32'h1);

        $display("[TB] test 1: read all registers after reset");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            tick();
            checkOutput($sformatf("t1_rs1_x%0d", i), rs1_data, 32'h0);
            checkOutput($sformatf("t1_rs2_x%0d", 31 - i), rs2_data, 32'h0);
        end

        $display("[TB] test 2: lone LUI x5");
        applyStimulus(1, mk_lui(20'hABCDE, 5'd5), 0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        checkOutput("t2_pending", {31'b0, lui_pending}, 32'h0);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        tick();
        checkOutput("t2_x5_rs1", rs1_data, 32'hABCDE000);
        checkOutput("t2_x5_rs2", rs2_data, 32'hABCDE000);

        $display("[TB] test 2b: non-LUI opcode is dropped");
        applyStimulus(1, {20'h11111, 5'd12, ALU}, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        checkOutput("t2b_ready", {31'b0, instr_ready}, 32'h1);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd12, 5'd0);
        tick();
        checkOutput("t2b_x12", rs1_data, 32'h0);

        $display("[TB] test 3: LUI x7 collides with ALU write x3");
        applyStimulus(1, mk_lui(20'h12345, 5'd7), 1, 5'd3, 32'hDEAD, 5'd0, 5'd0);
        tick();
        checkOutput("t3_pending",  {31'b0, lui_pending}, 32'h1);
        checkOutput("t3_pend_rd",  {27'b0, lui_pend_rd}, 32'h7);
        checkOutput("t3_ready_lo", {31'b0, instr_ready}, 32'h0);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd3, 5'd7);
        tick();
        checkOutput("t3_x3",         rs1_data, 32'h0000DEAD);
        checkOutput("t3_x7_bypass",  rs2_data, 32'h12345000);
        checkOutput("t3_pending_lo", {31'b0, lui_pending}, 32'h0);
        checkOutput("t3_pend_rd_lo", {27'b0, lui_pend_rd}, 32'h0);
        checkOutput("t3_ready_hi",   {31'b0, instr_ready}, 32'h1);
        tick();
        checkOutput("t3_x7_array", rs2_data, 32'h12345000);

        $display("[TB] test 4: write x9 with same-cycle read bypass");
        applyStimulus(0, 32'h0, 1, 5'd9, 32'h55, 5'd9, 5'd9);
        tick();
        checkOutput("t4_rs1_bypass", rs1_data, 32'h55);
        checkOutput("t4_rs2_bypass", rs2_data, 32'h55);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd3);
        tick();
        checkOutput("t4_rs1_array", rs1_data, 32'h55);
        checkOutput("t4_x3_kept",   rs2_data, 32'h0000DEAD);

        $display("[TB] test 5: LUI x0 and ALU x0 discarded");
        applyStimulus(1, mk_lui(20'hFFFFF, 5'd0), 1, 5'd0, 32'h1, 5'd0, 5'd0);
        tick();
        checkOutput("t5_x0_a", rs1_data, 32'h0);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        checkOutput("t5_x0_b",     rs1_data, 32'h0);
        checkOutput("t5_pending",  {31'b0, lui_pending}, 32'h0);
        checkOutput("t5_ready",    {31'b0, instr_ready}, 32'h1);
        tick();
        checkOutput("t5_x0_c", rs2_data, 32'h0);

        $display("[TB] test 6: stalled LUI does not overtake the held one");
        applyStimulus(1, mk_lui(20'hAAAAA, 5'd10), 1, 5'd11, 32'h11, 5'd0, 5'd0);
        tick();
        checkOutput("t6_ready_lo", {31'b0, instr_ready}, 32'h0);
        applyStimulus(1, mk_lui(20'hBBBBB, 5'd10), 0, 5'd0, 32'h0, 5'd10, 5'd11);
        tick();
        checkOutput("t6_first_lui", rs1_data, 32'hAAAAA000);
        checkOutput("t6_x11",       rs2_data, 32'h11);
        checkOutput("t6_ready_hi",  {31'b0, instr_ready}, 32'h1);
        tick();
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd10, 5'd0);
        tick();
        checkOutput("t6_second_lui", rs1_data, 32'hBBBBB000);

        $display("[TB] test 7: skid held by ALU traffic, then reset");
        applyStimulus(1, mk_lui(20'h0BEEF, 5'd20), 1, 5'd4, 32'h44, 5'd0, 5'd0);
        tick();
        applyStimulus(0, 32'h0, 1, 5'd4, 32'h45, 5'd0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("t7_pending_%0d", i), {31'b0, lui_pending}, 32'h1);
            checkOutput($sformatf("t7_pend_rd_%0d", i), {27'b0, lui_pend_rd}, 32'd20);
            checkOutput($sformatf("t7_ready_%0d", i),   {31'b0, instr_ready}, 32'h0);
            tick();
        end
        checkOutput("t7_pending_2", {31'b0, lui_pending}, 32'h1);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd4);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t7_rst_pending", {31'b0, lui_pending}, 32'h0);
        checkOutput("t7_rst_pend_rd", {27'b0, lui_pend_rd}, 32'h0);
        checkOutput("t7_rst_ready",   {31'b0, instr_ready}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t7_x20_zero", rs1_data, 32'h0);
        checkOutput("t7_x4_zero",  rs2_data, 32'h0);
        checkOutput("t7_pending_after", {31'b0, lui_pending}, 32'h0);
        applyStimulus(0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd9);
        tick();
        checkOutput("t7_x5_zero", rs1_data, 32'h0);
        checkOutput("t7_x9_zero", rs2_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
